count_wrap_monitor: RTL
=======================

Name: count_wrap_monitor

Overview:
- Downstream consumer of the MAX_VALUE up-counter's `count` output; same clock domain.
- Checks every cycle that `count` advances legally: +1, hold, or wrap MAX_VALUE->0.
- Produces registered event pulses, a saturating wrap tally, and a sticky step-error flag.
- Feeds status/interrupt logic and serves as the synthesizable checker counterpart for formal runs on the counter.

Parameters:
- WIDTH, 4, width of the monitored count bus.
- MAX_VALUE, 8, terminal value of the upstream counter; must be < 2**WIDTH.
- HOLD_OK, 1, 1 = count unchanged between cycles is legal; 0 = hold is a step error.
- WRAP_W, 8, width of the wrap tally.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- count  input  WIDTH  counter value, sampled every posedge.
- max_hit  output  1  one-cycle pulse: sampled count == MAX_VALUE on a cycle that was not already MAX_VALUE.
- wrap_pulse  output  1  one-cycle pulse: legal MAX_VALUE->0 transition observed.
- wrap_count  output  WRAP_W  number of legal wraps since reset; saturates at all-ones.
- step_err  output  1  sticky: illegal transition or out-of-range value seen.
- err_value  output  WIDTH  count value captured on the first error.
- mon_state  output  2  FSM state encoding: 0 = WAIT_FIRST, 1 = TRACK, 2 = FAULT.

Behaviour:
- Reset (async assert, sync release): state WAIT_FIRST, prev = 0, all outputs 0.
- WAIT_FIRST (one posedge only):
  - Capture count into prev.
  - If count > MAX_VALUE: step_err = 1, err_value = count, go FAULT.
  - Else go TRACK; if count == MAX_VALUE, pulse max_hit.
- TRACK: classify each sampled count against prev.
  - count == prev + 1 and prev < MAX_VALUE: legal. If count == MAX_VALUE, pulse max_hit.
  - count == 0 and prev == MAX_VALUE: legal wrap. Pulse wrap_pulse; increment wrap_count unless all-ones.
  - count == prev: legal if HOLD_OK = 1. No pulses; max_hit does not re-fire while holding at MAX_VALUE.
  - Anything else, including count > MAX_VALUE: step_err = 1, err_value = count, go FAULT.
  - prev is updated to count every cycle.
- FAULT: absorbing until reset.
  - step_err and err_value are held.
  - No further pulses; wrap_count frozen.
  - Only later errors are ignored; err_value keeps the first offending value.
- Latency: every output is registered and reflects the count sampled at the same posedge. Pulses are high for exactly one cycle after that posedge.
- Arithmetic: the prev + 1 compare is WIDTH+1 bits wide, so prev = all-ones cannot alias to 0.
- Saturation: at wrap_count = all-ones, a further wrap still pulses wrap_pulse, but the tally stays at all-ones.
- Reset mid-operation clears everything immediately, including a FAULT state; the next sample re-enters WAIT_FIRST.
- MAX_VALUE = 0 case: only count = 0 is legal. Each 0->0 sample counts as a wrap, independent of HOLD_OK.

Test Plan:
- Normal counting: reset high 10 ns, then count 0..8,0..8,0..3 (MAX_VALUE = 8).
  - max_hit pulses twice.
  - wrap_pulse pulses twice; wrap_count = 2.
  - step_err stays 0; mon_state = 1.
- Skip: drive 0,1,2,4.
  - step_err = 1, err_value = 4, mon_state = 2.
  - A subsequent 0 does not pulse wrap_pulse.
- Out of range: first sample after reset = 9.
  - step_err = 1 at the first posedge, err_value = 9.
- Hold: drive 3,3,4 with HOLD_OK = 1 -> no error. Same sequence with HOLD_OK = 0 -> step_err = 1, err_value = 3.
- Saturation: 300 legal wraps with WRAP_W = 8.
  - wrap_count = 255.
  - wrap_pulse still fires on wrap 300.
- Reset mid-run: assert reset while in FAULT, asynchronously between edges.
  - All outputs read 0 before the next posedge; mon_state = 0.
  - Legal counting afterwards gives no error.

Source files
------------

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_wrap_monitor
// Purpose  : Watches an up-counter that runs 0..MAX_VALUE and wraps. Every
//            posedge it checks that the counter made a legal step: +1, hold,
//            or MAX_VALUE->0. It produces one-cycle max/wrap event pulses, a
//            saturating wrap tally and a sticky error flag. The error flag
//            keeps the first offending value.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous assert, active-high reset
//            count      - monitored counter value [WIDTH]
//            max_hit    - pulse: count reached MAX_VALUE from a different value
//            wrap_pulse - pulse: legal MAX_VALUE->0 wrap observed
//            wrap_count - number of legal wraps, saturating [WRAP_W]
//            step_err   - sticky: illegal step or out-of-range value seen
//            err_value  - count value captured on the first error [WIDTH]
//            mon_state  - 0 = WAIT_FIRST, 1 = TRACK, 2 = FAULT
// Revision : 1.0 - initial release
// ============================================================================
module count_wrap_monitor #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 8,
  parameter int HOLD_OK   = 1,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count,
  output logic              max_hit,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic [WIDTH-1:0]  err_value,
  output logic [1:0]        mon_state
);

  localparam logic [WIDTH-1:0]  C_MAX_V     = WIDTH'(MAX_VALUE);
  localparam logic              C_HOLD_OK   = (HOLD_OK != 0);
  localparam logic [WRAP_W-1:0] C_WRAP_FULL = {WRAP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_TRACK      = 2'd1,
    ST_FAULT      = 2'd2
  } mon_state_e;

  mon_state_e        state_q,      state_d;
  logic [WIDTH-1:0]  prev_q,       prev_d;
  logic              max_hit_q,    max_hit_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              step_err_q,   step_err_d;
  logic [WIDTH-1:0]  err_value_q,  err_value_d;

  // The increment is one bit wider than the bus, so prev = all-ones gives
  // 2**WIDTH here. It cannot alias to a count of 0.
  logic [WIDTH:0] w_prev_inc;
  logic [WIDTH:0] w_count_ext;
  logic           w_in_range;
  logic           w_is_wrap;
  logic           w_is_step;
  logic           w_is_hold;

  assign w_prev_inc  = {1'b0, prev_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_count_ext = {1'b0, count};
  assign w_in_range  = (count <= C_MAX_V);
  // The wrap check has priority over the hold check. With MAX_VALUE = 0, a
  // 0->0 sample is therefore a wrap whatever HOLD_OK is set to.
  assign w_is_wrap   = (prev_q == C_MAX_V) && (count == '0);
  assign w_is_step   = (prev_q < C_MAX_V) && (w_count_ext == w_prev_inc);
  assign w_is_hold   = C_HOLD_OK && (count == prev_q);

  always_comb begin
    state_d      = state_q;
    prev_d       = count;
    max_hit_d    = 1'b0;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;
    step_err_d   = step_err_q;
    err_value_d  = err_value_q;

    case (state_q)
      ST_WAIT_FIRST: begin
        if (!w_in_range) begin
          step_err_d  = 1'b1;
          err_value_d = count;
          state_d     = ST_FAULT;
        end else begin
          max_hit_d = (count == C_MAX_V);
          state_d   = ST_TRACK;
        end
      end

      ST_TRACK: begin
        if (w_is_wrap) begin
          wrap_pulse_d = 1'b1;
          if (wrap_count_q != C_WRAP_FULL) begin
            wrap_count_d = wrap_count_q + 1'b1;
          end
        end else if (w_is_step) begin
          max_hit_d = (count == C_MAX_V);
        end else if (w_is_hold) begin
          // Legal hold: no events. A hold at MAX_VALUE must not re-fire max_hit.
        end else begin
          step_err_d  = 1'b1;
          err_value_d = count;
          state_d     = ST_FAULT;
        end
      end

      ST_FAULT: begin
        // FAULT is absorbing. The first error's value is kept until reset.
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_FIRST;
      prev_q       <= '0;
      max_hit_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
      step_err_q   <= 1'b0;
      err_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      max_hit_q    <= max_hit_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      step_err_q   <= step_err_d;
      err_value_q  <= err_value_d;
    end
  end

  assign max_hit    = max_hit_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign step_err   = step_err_q;
  assign err_value  = err_value_q;
  assign mon_state  = state_q;

endmodule
`default_nettype wire
